// File: rtl/param_rr_stream_mux_pkg.sv
// Shared widths, the port-index type and a select-width helper for the stream mux.
package param_rr_stream_mux_pkg;

  localparam int unsigned PORT_IDX_W = 16;

  typedef logic [PORT_IDX_W-1:0] port_idx_t;

  // Width of a port index; at least one bit even for degenerate counts.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/param_rr_stream_mux_rr_arbiter.sv
// Round-robin arbiter: first requester at or above the priority pointer wins,
// pointer moves past the committed index.
module param_rr_stream_mux_rr_arbiter
  import param_rr_stream_mux_pkg::*;
#(
  parameter  int unsigned nports = 4,
  localparam int unsigned SW     = sel_width(nports)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [nports-1:0] req,
  input  logic              en,
  input  logic              commit,
  input  logic [SW-1:0]     commit_idx,
  output logic [nports-1:0] grant_c
);

  logic [SW-1:0] ptr_q, ptr_d;
  logic          found;
  int unsigned   idx;

  // Wrapping priority search starting at the pointer.
  always_comb begin
    grant_c = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned k = 0; k < nports; k++) begin
      idx = (32'(ptr_q) + k) % nports;
      if (en && !found && req[SW'(idx)]) begin
        grant_c[SW'(idx)] = 1'b1;
        found             = 1'b1;
      end
    end
  end

  // Pointer advances to the port after the one that just finished a packet.
  always_comb begin
    ptr_d = ptr_q;
    if (commit) begin
      ptr_d = (32'(commit_idx) == nports - 1) ? '0 : SW'(32'(commit_idx) + 1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/param_rr_stream_mux.sv
// N-to-1 val/rdy stream mux: round-robin or forced selection, optional packet
// lock, single registered output stage.
module param_rr_stream_mux
  import param_rr_stream_mux_pkg::*;
#(
  parameter  int unsigned nbits    = 32,
  parameter  int unsigned nports   = 4,
  parameter  int unsigned pkt_lock = 0,
  localparam int unsigned SW       = sel_width(nports)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [nports-1:0]       in_val,
  output logic [nports-1:0]       in_rdy,
  input  logic [nports*nbits-1:0] in_msg,
  input  logic [nports-1:0]       in_last,
  input  logic                    force_en,
  input  logic [SW-1:0]           force_sel,
  output logic                    out_val,
  input  logic                    out_rdy,
  output logic [nbits-1:0]        out_msg,
  output logic [SW-1:0]           out_src
);

  logic              out_val_q, out_val_d;
  logic [nbits-1:0]  out_msg_q, out_msg_d;
  logic [SW-1:0]     out_src_q, out_src_d;
  logic              lock_q, lock_d;
  logic [SW-1:0]     lock_idx_q, lock_idx_d;
  logic              lock_force_q, lock_force_d;

  logic              en;
  logic              force_ok;
  logic              is_forced;
  logic [nports-1:0] arb_grant_c;
  logic [nports-1:0] grant_raw;
  logic [nports-1:0] grant;
  logic              xfer;
  logic [SW-1:0]     xfer_idx;
  logic [nbits-1:0]  xfer_msg;
  logic              xfer_last;
  logic              pkt_end;
  logic              commit;

  assign en       = !out_val_q || out_rdy;
  assign force_ok = port_idx_t'(force_sel) < port_idx_t'(nports);

  param_rr_stream_mux_rr_arbiter #(.nports(nports)) u_arb (
    .clk        (clk),
    .rst_n      (reset_n),
    .req        (in_val),
    .en         (en && reset_n),
    .commit     (commit),
    .commit_idx (xfer_idx),
    .grant_c    (arb_grant_c)
  );

  // Grant source: an open packet owns the port, else force, else round robin.
  always_comb begin
    grant_raw = '0;
    is_forced = 1'b0;
    if (lock_q) begin
      grant_raw[lock_idx_q] = in_val[lock_idx_q];
      is_forced             = lock_force_q;
    end else if (force_en) begin
      is_forced = 1'b1;
      if (force_ok) grant_raw[force_sel] = in_val[force_sel];
    end else begin
      grant_raw = arb_grant_c;
    end
  end

  assign grant  = grant_raw & {nports{en && reset_n}};
  assign in_rdy = grant;
  assign xfer   = |grant;

  // Pick the granted port's payload and last flag.
  always_comb begin
    xfer_idx  = '0;
    xfer_msg  = '0;
    xfer_last = 1'b0;
    for (int unsigned i = 0; i < nports; i++) begin
      if (grant[i]) begin
        xfer_idx  = SW'(i);
        xfer_msg  = in_msg[i*nbits +: nbits];
        xfer_last = in_last[i];
      end
    end
  end

  assign pkt_end = (pkt_lock == 0) || xfer_last;
  assign commit  = xfer && pkt_end && !is_forced;

  // Output register refill/drain and packet lock tracking.
  always_comb begin
    out_val_d    = out_val_q;
    out_msg_d    = out_msg_q;
    out_src_d    = out_src_q;
    lock_d       = lock_q;
    lock_idx_d   = lock_idx_q;
    lock_force_d = lock_force_q;
    if (xfer) begin
      out_val_d = 1'b1;
      out_msg_d = xfer_msg;
      out_src_d = xfer_idx;
      if (pkt_lock != 0) begin
        lock_d       = !xfer_last;
        lock_idx_d   = xfer_idx;
        lock_force_d = is_forced;
      end
    end else if (out_rdy) begin
      out_val_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_val_q    <= 1'b0;
      out_msg_q    <= '0;
      out_src_q    <= '0;
      lock_q       <= 1'b0;
      lock_idx_q   <= '0;
      lock_force_q <= 1'b0;
    end else begin
      out_val_q    <= out_val_d;
      out_msg_q    <= out_msg_d;
      out_src_q    <= out_src_d;
      lock_q       <= lock_d;
      lock_idx_q   <= lock_idx_d;
      lock_force_q <= lock_force_d;
    end
  end

  assign out_val = out_val_q;
  assign out_msg = out_msg_q;
  assign out_src = out_src_q;

endmodule

// File: tb/tb_param_rr_stream_mux.sv
// Bench for param_rr_stream_mux: instance 0 without packet lock, instance 1
// with packet lock, both driven by the same stimulus and tracked by a model.
module tb_param_rr_stream_mux;

  localparam int unsigned NB = 32;
  localparam int unsigned NP = 4;

  logic              clk;
  logic              reset_n;
  logic [NP-1:0]     in_val;
  logic [NP-1:0]     in_last;
  logic [NB-1:0]     msgs [NP];
  logic [NP*NB-1:0]  in_msg;
  logic              force_en;
  logic [1:0]        force_sel;
  logic              out_rdy;

  wire [1:0][NP-1:0] rdy_o;
  wire [1:0]         val_o;
  wire [1:0][NB-1:0] msg_o;
  wire [1:0][1:0]    src_o;

  int checks;
  int errors;

  // Model state per instance (index 0: no lock, index 1: lock).
  logic          m_val  [2];
  logic [NB-1:0] m_msg  [2];
  int            m_src  [2];
  int            m_ptr  [2];
  bit            m_lock [2];
  int            m_lidx [2];
  bit            m_lf   [2];
  int            g      [2];
  bit            gf     [2];
  logic [NP-1:0] exp_rdy[2];

  assign in_msg = {msgs[3], msgs[2], msgs[1], msgs[0]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  param_rr_stream_mux #(.nbits(NB), .nports(NP), .pkt_lock(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .in_val(in_val), .in_rdy(rdy_o[0]),
    .in_msg(in_msg), .in_last(in_last), .force_en(force_en), .force_sel(force_sel),
    .out_val(val_o[0]), .out_rdy(out_rdy), .out_msg(msg_o[0]), .out_src(src_o[0])
  );

  param_rr_stream_mux #(.nbits(NB), .nports(NP), .pkt_lock(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .in_val(in_val), .in_rdy(rdy_o[1]),
    .in_msg(in_msg), .in_last(in_last), .force_en(force_en), .force_sel(force_sel),
    .out_val(val_o[1]), .out_rdy(out_rdy), .out_msg(msg_o[1]), .out_src(src_o[1])
  );

  task automatic mreset();
    for (int k = 0; k < 2; k++) begin
      m_val[k] = 1'b0; m_msg[k] = '0; m_src[k] = 0; m_ptr[k] = 0;
      m_lock[k] = 1'b0; m_lidx[k] = 0; m_lf[k] = 1'b0;
    end
  endtask

  // Which port each instance accepts from under the current inputs.
  task automatic predict();
    for (int k = 0; k < 2; k++) begin
      g[k]  = -1;
      gf[k] = 1'b0;
      if (reset_n && (!m_val[k] || out_rdy)) begin
        if (m_lock[k]) begin
          if (in_val[m_lidx[k]]) g[k] = m_lidx[k];
          gf[k] = m_lf[k];
        end else if (force_en) begin
          gf[k] = 1'b1;
          if (int'(force_sel) < int'(NP) && in_val[force_sel]) g[k] = int'(force_sel);
        end else begin
          for (int off = 0; off < int'(NP); off++) begin
            if (g[k] < 0 && in_val[(m_ptr[k] + off) % int'(NP)]) g[k] = (m_ptr[k] + off) % int'(NP);
          end
        end
      end
      exp_rdy[k] = (g[k] < 0) ? 4'b0000 : 4'(1 << g[k]);
    end
  endtask

  task automatic apply();
    bit last;
    for (int k = 0; k < 2; k++) begin
      if (g[k] >= 0) begin
        last     = (k == 0) ? 1'b1 : in_last[g[k]];
        m_val[k] = 1'b1;
        m_msg[k] = msgs[g[k]];
        m_src[k] = g[k];
        if (last && !gf[k]) m_ptr[k] = (g[k] + 1) % int'(NP);
        if (k == 1) begin
          m_lock[k] = !last;
          m_lidx[k] = g[k];
          m_lf[k]   = gf[k];
        end
      end else if (out_rdy) begin
        m_val[k] = 1'b0;
      end
    end
  endtask

  task automatic tick();
    predict();
    @(posedge clk);
    apply();
    #1;
  endtask

  task automatic apply_reset();
    in_val = '0; in_last = '0; force_en = 1'b0; force_sel = '0; out_rdy = 1'b1;
    for (int i = 0; i < int'(NP); i++) msgs[i] = 32'hA0 + 32'(i);
    reset_n = 1'b0;
    mreset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < int'(NP); i++) msgs[i] = 32'hA0 + 32'(i);
    in_val = '1; in_last = '1; force_en = 1'b0; force_sel = '0; out_rdy = 1'b1;
    reset_n = 1'b0;
    mreset();
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (val_o[k] !== 1'b0 || rdy_o[k] !== 4'b0000 || msg_o[k] !== 32'h0 || src_o[k] !== 2'd0) begin
        errors++;
        $display("FAIL reset_hold dut%0d: got val=%b rdy=%b msg=%h src=%0d, expected 0/0000/0/0",
                 k, val_o[k], rdy_o[k], msg_o[k], src_o[k]);
      end
    end
    reset_n = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (rdy_o[k] !== 4'b0001) begin
        errors++;
        $display("FAIL reset_first_grant dut%0d: got rdy=%b expected 0001", k, rdy_o[k]);
      end
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (val_o[k] !== 1'b1 || src_o[k] !== 2'd0 || msg_o[k] !== 32'hA0) begin
        errors++;
        $display("FAIL reset_first_beat dut%0d: got val=%b src=%0d msg=%h expected 1/0/a0",
                 k, val_o[k], src_o[k], msg_o[k]);
      end
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    in_val = '1; in_last = '1;
    for (int c = 0; c < 5; c++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (val_o[k] !== 1'b1 || src_o[k] !== 2'(c % 4) || msg_o[k] !== 32'hA0 + 32'(c % 4)) begin
          errors++;
          $display("FAIL rr_seq dut%0d cyc%0d: got val=%b src=%0d msg=%h expected 1/%0d/%h",
                   k, c, val_o[k], src_o[k], msg_o[k], c % 4, 32'hA0 + 32'(c % 4));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    in_val = '1; in_last = '1;
    tick();
    tick();
    out_rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (rdy_o[k] !== 4'b0000) begin
          errors++;
          $display("FAIL bp_rdy dut%0d cyc%0d: got rdy=%b expected 0000", k, c, rdy_o[k]);
        end
      end
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (val_o[k] !== 1'b1 || src_o[k] !== 2'd1 || msg_o[k] !== 32'hA1) begin
          errors++;
          $display("FAIL bp_hold dut%0d cyc%0d: got val=%b src=%0d msg=%h expected 1/1/a1",
                   k, c, val_o[k], src_o[k], msg_o[k]);
        end
      end
    end
    out_rdy = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (rdy_o[k] !== 4'b0100) begin
        errors++;
        $display("FAIL bp_release_rdy dut%0d: got rdy=%b expected 0100", k, rdy_o[k]);
      end
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (val_o[k] !== 1'b1 || src_o[k] !== 2'd2 || msg_o[k] !== 32'hA2) begin
        errors++;
        $display("FAIL bp_next dut%0d: got val=%b src=%0d msg=%h expected 1/2/a2",
                 k, val_o[k], src_o[k], msg_o[k]);
      end
    end
  endtask

  task automatic test_force();
    apply_reset();
    in_val = 4'b0110; in_last = '1; force_en = 1'b1; force_sel = 2'd2;
    for (int c = 0; c < 3; c++) begin
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (rdy_o[k] !== 4'b0100) begin
          errors++;
          $display("FAIL force_rdy dut%0d cyc%0d: got rdy=%b expected 0100", k, c, rdy_o[k]);
        end
      end
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (val_o[k] !== 1'b1 || src_o[k] !== 2'd2 || msg_o[k] !== 32'hA2) begin
          errors++;
          $display("FAIL force_out dut%0d cyc%0d: got val=%b src=%0d msg=%h expected 1/2/a2",
                   k, c, val_o[k], src_o[k], msg_o[k]);
        end
      end
    end
    force_sel = 2'd3;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (rdy_o[k] !== 4'b0000) begin
        errors++;
        $display("FAIL force_none_rdy dut%0d: got rdy=%b expected 0000", k, rdy_o[k]);
      end
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (val_o[k] !== 1'b0) begin
        errors++;
        $display("FAIL force_none_val dut%0d: got val=%b expected 0", k, val_o[k]);
      end
    end
    force_en = 1'b0; in_val = '1;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (rdy_o[k] !== 4'b0001) begin
        errors++;
        $display("FAIL force_ptr_kept dut%0d: got rdy=%b expected 0001", k, rdy_o[k]);
      end
    end
    tick();
  endtask

  task automatic test_packet_lock();
    apply_reset();
    in_val = 4'b0110; in_last = 4'b0100;
    for (int b = 1; b <= 3; b++) begin
      in_last[1] = (b == 3);
      force_en   = (b == 2);
      force_sel  = 2'd2;
      #1;
      checks++;
      if (rdy_o[1] !== 4'b0010) begin
        errors++;
        $display("FAIL lock_rdy beat%0d: got rdy=%b expected 0010", b, rdy_o[1]);
      end
      predict();
      checks++;
      if (rdy_o[0] !== exp_rdy[0]) begin
        errors++;
        $display("FAIL lock_nolock_rdy beat%0d: got rdy=%b expected %b", b, rdy_o[0], exp_rdy[0]);
      end
      tick();
      checks++;
      if (val_o[1] !== 1'b1 || src_o[1] !== 2'd1 || msg_o[1] !== 32'hA1) begin
        errors++;
        $display("FAIL lock_beat%0d: got val=%b src=%0d msg=%h expected 1/1/a1",
                 b, val_o[1], src_o[1], msg_o[1]);
      end
      checks++;
      if (src_o[0] !== 2'(m_src[0]) || msg_o[0] !== m_msg[0]) begin
        errors++;
        $display("FAIL lock_nolock_out beat%0d: got src=%0d msg=%h expected %0d/%h",
                 b, src_o[0], msg_o[0], m_src[0], m_msg[0]);
      end
    end
    force_en = 1'b0;
    #1;
    checks++;
    if (rdy_o[1] !== 4'b0100) begin
      errors++;
      $display("FAIL lock_ptr_adv: got rdy=%b expected 0100", rdy_o[1]);
    end
    tick();
    checks++;
    if (val_o[1] !== 1'b1 || src_o[1] !== 2'd2) begin
      errors++;
      $display("FAIL lock_after: got val=%b src=%0d expected 1/2", val_o[1], src_o[1]);
    end
  endtask

  task automatic test_reset_mid_packet();
    apply_reset();
    in_val = 4'b1000; in_last = '0;
    tick();
    checks++;
    if (val_o[1] !== 1'b1 || src_o[1] !== 2'd3) begin
      errors++;
      $display("FAIL midrst_beat1: got val=%b src=%0d expected 1/3", val_o[1], src_o[1]);
    end
    in_val  = '1;
    reset_n = 1'b0;
    mreset();
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (val_o[k] !== 1'b0 || rdy_o[k] !== 4'b0000) begin
        errors++;
        $display("FAIL midrst_hold dut%0d: got val=%b rdy=%b expected 0/0000", k, val_o[k], rdy_o[k]);
      end
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    checks++;
    if (rdy_o[1] !== 4'b0001) begin
      errors++;
      $display("FAIL midrst_regrant: got rdy=%b expected 0001", rdy_o[1]);
    end
    tick();
    checks++;
    if (val_o[1] !== 1'b1 || src_o[1] !== 2'd0) begin
      errors++;
      $display("FAIL midrst_out: got val=%b src=%0d expected 1/0", val_o[1], src_o[1]);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      in_val    = 4'($urandom);
      in_last   = 4'($urandom);
      out_rdy   = ($urandom % 4) != 0;
      force_en  = ($urandom % 5) == 0;
      force_sel = 2'($urandom);
      for (int i = 0; i < int'(NP); i++) msgs[i] = $urandom;
      #1;
      predict();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (rdy_o[k] !== exp_rdy[k]) begin
          errors++;
          $display("FAIL rand_rdy dut%0d cyc%0d: got rdy=%b expected %b", k, c, rdy_o[k], exp_rdy[k]);
        end
      end
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (val_o[k] !== m_val[k] || src_o[k] !== 2'(m_src[k]) || msg_o[k] !== m_msg[k]) begin
          errors++;
          $display("FAIL rand_out dut%0d cyc%0d: got val=%b src=%0d msg=%h expected %b/%0d/%h",
                   k, c, val_o[k], src_o[k], msg_o[k], m_val[k], m_src[k], m_msg[k]);
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    in_val = '0; in_last = '0; force_en = 1'b0; force_sel = '0; out_rdy = 1'b1;
    for (int i = 0; i < int'(NP); i++) msgs[i] = '0;
    mreset();
    #2;
    test_reset();
    test_round_robin();
    test_backpressure();
    test_force();
    test_packet_lock();
    test_reset_mid_packet();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
